apb_master_bridge: RTL and testbench

//  APB initiator that converts a simple single-outstanding command/response

---
 rtl/apb_master_bridge_if.sv | 40 ++++
 rtl/apb_master_bridge.sv | 147 ++++++++++++++
 tb/tb_apb_master_bridge.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_bridge_if.sv
// Bundle of the command/response handshake and the APB bus driven by
// apb_master_bridge. The master modport is the bridge's view; the slave
// modport is the view of whatever surrounds it (driver plus APB slave).
interface apb_master_bridge_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [4:0]  addr;
  logic [31:0] pwdata;
  logic [3:0]  pstrobe;
  logic [2:0]  Prot;
  logic        pready;
  logic        pslverr;
  logic [31:0] prdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    input  pready, pslverr, prdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, pwrite, addr, pwdata, pstrobe, Prot
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    output pready, pslverr, prdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, pwrite, addr, pwdata, pstrobe, Prot
  );
endinterface

// File: rtl/apb_master_bridge.sv
// APB initiator: takes one command at a time, runs an APB setup/access
// transfer with wait-state support and an optional pready timeout, and
// returns a one-cycle response pulse. Every output comes from a register.
module apb_master_bridge #(
  parameter int TIMEOUT_CYCLES = 16,  // 0 disables the timeout
  parameter int CNT_W          = 8
) (
  input logic                 clk,
  input logic                 resetn,
  apb_master_bridge_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST  =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              cmd_ready_reg, cmd_ready_next;
  logic              psel_reg, psel_next;
  logic              penable_reg, penable_next;
  logic              pwrite_reg, pwrite_next;
  logic [4:0]        addr_reg, addr_next;
  logic [31:0]       pwdata_reg, pwdata_next;
  logic [3:0]        pstrobe_reg, pstrobe_next;
  logic [2:0]        prot_reg, prot_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic [31:0]       rsp_rdata_reg, rsp_rdata_next;
  logic              rsp_err_reg, rsp_err_next;
  logic              rsp_timeout_reg, rsp_timeout_next;

  // State, wait counter and all output registers; reset leaves only cmd_ready set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      cmd_ready_reg   <= 1'b1;
      psel_reg        <= 1'b0;
      penable_reg     <= 1'b0;
      pwrite_reg      <= 1'b0;
      addr_reg        <= '0;
      pwdata_reg      <= '0;
      pstrobe_reg     <= '0;
      prot_reg        <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_err_reg     <= 1'b0;
      rsp_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      cmd_ready_reg   <= cmd_ready_next;
      psel_reg        <= psel_next;
      penable_reg     <= penable_next;
      pwrite_reg      <= pwrite_next;
      addr_reg        <= addr_next;
      pwdata_reg      <= pwdata_next;
      pstrobe_reg     <= pstrobe_next;
      prot_reg        <= prot_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_rdata_reg   <= rsp_rdata_next;
      rsp_err_reg     <= rsp_err_next;
      rsp_timeout_reg <= rsp_timeout_next;
    end
  end

  // Next-state and next-output logic; everything holds unless a state acts on it.
  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    cmd_ready_next   = cmd_ready_reg;
    psel_next        = psel_reg;
    penable_next     = penable_reg;
    pwrite_next      = pwrite_reg;
    addr_next        = addr_reg;
    pwdata_next      = pwdata_reg;
    pstrobe_next     = pstrobe_reg;
    prot_next        = prot_reg;
    rsp_valid_next   = 1'b0;  // response is a single-cycle pulse
    rsp_rdata_next   = rsp_rdata_reg;
    rsp_err_next     = rsp_err_reg;
    rsp_timeout_next = rsp_timeout_reg;

    case (state_reg)
      IDLE: begin
        if (bus.cmd_valid) begin
          pwrite_next    = bus.cmd_write;
          addr_next      = bus.cmd_addr;
          pwdata_next    = bus.cmd_wdata;
          pstrobe_next   = bus.cmd_strb;
          prot_next      = bus.cmd_prot;
          cmd_ready_next = 1'b0;
          psel_next      = 1'b1;
          cnt_next       = '0;
          state_next     = SETUP;
        end
      end
      SETUP: begin
        penable_next = 1'b1;
        state_next   = ACCESS;
      end
      ACCESS: begin
        // pready wins over the timeout when both land on the same cycle
        if (bus.pready) begin
          psel_next        = 1'b0;
          penable_next     = 1'b0;
          cmd_ready_next   = 1'b1;
          rsp_valid_next   = 1'b1;
          rsp_err_next     = bus.pslverr;
          rsp_timeout_next = 1'b0;
          rsp_rdata_next   = pwrite_reg ? 32'd0 : bus.prdata;
          state_next       = IDLE;
        end else if (TIMEOUT_EN && (cnt_reg == CNT_LAST)) begin
          psel_next        = 1'b0;
          penable_next     = 1'b0;
          cmd_ready_next   = 1'b1;
          rsp_valid_next   = 1'b1;
          rsp_err_next     = 1'b1;
          rsp_timeout_next = 1'b1;
          rsp_rdata_next   = 32'd0;
          state_next       = IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.cmd_ready   = cmd_ready_reg;
  assign bus.psel        = psel_reg;
  assign bus.penable     = penable_reg;
  assign bus.pwrite      = pwrite_reg;
  assign bus.addr        = addr_reg;
  assign bus.pwdata      = pwdata_reg;
  assign bus.pstrobe     = pstrobe_reg;
  assign bus.Prot        = prot_reg;
  assign bus.rsp_valid   = rsp_valid_reg;
  assign bus.rsp_rdata   = rsp_rdata_reg;
  assign bus.rsp_err     = rsp_err_reg;
  assign bus.rsp_timeout = rsp_timeout_reg;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: vector table of commands with expected
// responses, a scoreboard checked by a negedge monitor, a small APB slave
// memory model, and hand sequences for back-to-back and mid-transfer reset.
module tb_apb_master_bridge;

  localparam int TO = 4;
  localparam int NV = 11;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  apb_master_bridge_if bus();

  apb_master_bridge #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // ---------------- APB slave model ----------------
  logic [31:0] mem [32];
  int unsigned slv_waits = 0;
  logic        slv_err = 1'b0;
  int unsigned wcnt = 0;

  assign bus.pready  = bus.psel && bus.penable && (wcnt == slv_waits);
  assign bus.pslverr = slv_err;
  assign bus.prdata  = mem[bus.addr];

  always @(posedge clk) begin
    if (bus.psel && bus.penable && !bus.pready) wcnt <= wcnt + 1;
    else                                        wcnt <= 0;
    if (bus.psel && bus.penable && bus.pready && bus.pwrite && !slv_err) begin
      for (int b = 0; b < 4; b++)
        if (bus.pstrobe[b]) mem[bus.addr][8*b +: 8] <= bus.pwdata[8*b +: 8];
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
    int          cyc;
    int          id;
  } rsp_t;

  typedef struct {
    logic        w;
    logic [4:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [2:0]  p;
  } apb_t;

  rsp_t sb[$];
  apb_t aq[$];

  int n_vec = 0;
  int n_err = 0;
  int ncyc = 0;
  int psel_cnt = 0;
  int pen_cnt = 0;
  int rsp_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  // Monitor: all DUT outputs sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      if (bus.psel) psel_cnt++;
      if (bus.penable) pen_cnt++;
      if (bus.psel && aq.size() > 0) begin
        chk("apb_pwrite", bus.pwrite, aq[0].w);
        chk("apb_addr", bus.addr, aq[0].a);
        chk("apb_pwdata", bus.pwdata, aq[0].d);
        chk("apb_pstrobe", bus.pstrobe, aq[0].s);
        chk("apb_prot", bus.Prot, aq[0].p);
        if (bus.penable && bus.pready) void'(aq.pop_front());
      end
      if (bus.rsp_valid) begin
        rsp_seen++;
        if (sb.size() == 0) begin
          chk("spurious_rsp_valid", 32'd1, 32'd0);
        end else begin
          rsp_t e;
          e = sb.pop_front();
          chk("rsp_cycle", ncyc, e.cyc);
          chk("rsp_rdata", bus.rsp_rdata, e.rdata);
          chk("rsp_err", bus.rsp_err, e.err);
          chk("rsp_timeout", bus.rsp_timeout, e.to);
          $display("txn %0d: rsp rdata=%h err=%b timeout=%b at cycle %0d", e.id,
                   bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout, ncyc);
        end
      end else if (sb.size() > 0 && ncyc > sb[0].cyc) begin
        rsp_t e;
        e = sb.pop_front();
        chk("rsp_valid_missing", 32'd0, 32'd1);
        $display("txn %0d: no response by cycle %0d", e.id, e.cyc);
      end
    end
  end

  // Presents a command (called at negedge+1 or posedge+1), waits for the
  // cycle in which it is accepted, pushes the expectations, and returns just
  // after the accepting edge with cmd_valid still high.
  task automatic send(input int id, input logic w, input logic [4:0] a,
                      input logic [31:0] d, input logic [3:0] s, input logic [2:0] p,
                      input int lat, input logic [31:0] e_rdata, input logic e_err,
                      input logic e_to, output int k);
    int guard;
    rsp_t r;
    apb_t q;
    guard = 0;
    k = -1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_strb  = s;
    bus.cmd_prot  = p;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!bus.cmd_ready) begin
      chk("cmd_ready_wait", 32'd0, 32'd1);
    end else begin
      k = ncyc;
      r.rdata = e_rdata; r.err = e_err; r.to = e_to; r.cyc = ncyc + lat; r.id = id;
      sb.push_back(r);
      q.w = w; q.a = a; q.d = d; q.s = s; q.p = p;
      aq.push_back(q);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        w;
    logic [4:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [2:0]  p;
    int          waits;
    logic        serr;
    logic [31:0] e_rdata;
    logic        e_err;
    logic        e_to;
    int          e_lat;   // falling edges from the accepting cycle to rsp_valid
    int          e_psel;  // sampled cycles with psel high
    int          e_pen;   // sampled cycles with penable high
  } vec_t;

  vec_t vt[NV];

  initial begin
    int k1, k2, seen, guard;

    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_strb  = '0;
    bus.cmd_prot  = '0;
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    mem[5] = 32'hFFFF_FFFF;

    vt[0]  = '{1'b1, 5'd5,  32'hA5A5_1234, 4'b0011, 3'b000, 0,   1'b0, 32'h0000_0000, 1'b0, 1'b0, 3, 2, 1};
    vt[1]  = '{1'b0, 5'd5,  32'h0000_0000, 4'b0000, 3'b010, 0,   1'b0, 32'hFFFF_1234, 1'b0, 1'b0, 3, 2, 1};
    vt[2]  = '{1'b0, 5'd5,  32'h0000_0000, 4'b0000, 3'b000, 3,   1'b0, 32'hFFFF_1234, 1'b0, 1'b0, 6, 5, 4};
    vt[3]  = '{1'b0, 5'd5,  32'h0000_0000, 4'b0000, 3'b000, 255, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 6, 5, 4};
    vt[4]  = '{1'b0, 5'd5,  32'h0000_0000, 4'b0000, 3'b001, 0,   1'b1, 32'hFFFF_1234, 1'b1, 1'b0, 3, 2, 1};
    vt[5]  = '{1'b1, 5'd3,  32'hDEAD_BEEF, 4'b1100, 3'b101, 1,   1'b0, 32'h0000_0000, 1'b0, 1'b0, 4, 3, 2};
    vt[6]  = '{1'b0, 5'd3,  32'h0000_0000, 4'b0000, 3'b111, 0,   1'b0, 32'hDEAD_0000, 1'b0, 1'b0, 3, 2, 1};
    vt[7]  = '{1'b1, 5'd31, 32'h1234_5678, 4'b1111, 3'b000, 0,   1'b1, 32'h0000_0000, 1'b1, 1'b0, 3, 2, 1};
    vt[8]  = '{1'b0, 5'd31, 32'h0000_0000, 4'b0000, 3'b000, 2,   1'b0, 32'h0000_0000, 1'b0, 1'b0, 5, 4, 3};
    vt[9]  = '{1'b1, 5'd5,  32'h00C0_0000, 4'b0100, 3'b000, 3,   1'b0, 32'h0000_0000, 1'b0, 1'b0, 6, 5, 4};
    vt[10] = '{1'b0, 5'd5,  32'h0000_0000, 4'b0000, 3'b000, 0,   1'b0, 32'hFFC0_1234, 1'b0, 1'b0, 3, 2, 1};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset_cmd_ready", bus.cmd_ready, 32'd1);
    chk("reset_psel", bus.psel, 32'd0);
    chk("reset_penable", bus.penable, 32'd0);
    chk("reset_rsp_valid", bus.rsp_valid, 32'd0);
    chk("reset_rsp_err", bus.rsp_err, 32'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("reset_addr", bus.addr, 32'd0);
    chk("reset_pwdata", bus.pwdata, 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    // Table-driven transfers
    for (int i = 0; i < NV; i++) begin
      slv_waits = vt[i].waits;
      slv_err   = vt[i].serr;
      psel_cnt  = 0;
      pen_cnt   = 0;
      send(i, vt[i].w, vt[i].a, vt[i].d, vt[i].s, vt[i].p, vt[i].e_lat,
           vt[i].e_rdata, vt[i].e_err, vt[i].e_to, k1);
      bus.cmd_valid = 1'b0;
      drain();
      if (vt[i].e_to && aq.size() > 0) void'(aq.pop_front());
      chk("psel_cycles", psel_cnt, vt[i].e_psel);
      chk("penable_cycles", pen_cnt, vt[i].e_pen);
      @(negedge clk);
      #1;
    end

    // Back-to-back: second command accepted in the response cycle of the first
    slv_waits = 0;
    slv_err   = 1'b0;
    send(100, 1'b1, 5'd9, 32'h1111_2222, 4'b1111, 3'b000, 3, 32'h0, 1'b0, 1'b0, k1);
    send(101, 1'b0, 5'd9, 32'h0, 4'b0000, 3'b000, 3, 32'h1111_2222, 1'b0, 1'b0, k2);
    bus.cmd_valid = 1'b0;
    drain();
    chk("b2b_accept_cycle", k2, k1 + 3);
    @(negedge clk);
    #1;

    // Reset during ACCESS: bus drops at once, no response for the lost command
    slv_waits = 255;
    send(200, 1'b0, 5'd5, 32'h0, 4'b0000, 3'b000, 6, 32'h0, 1'b1, 1'b1, k1);
    bus.cmd_valid = 1'b0;
    guard = 0;
    while (!bus.penable && guard < 10) begin
      @(negedge clk);
      #1;
      guard++;
    end
    chk("reach_access", bus.penable, 32'd1);
    resetn = 1'b0;
    #1;
    chk("midreset_psel", bus.psel, 32'd0);
    chk("midreset_penable", bus.penable, 32'd0);
    chk("midreset_cmd_ready", bus.cmd_ready, 32'd1);
    sb.delete();
    aq.delete();
    seen = rsp_seen;
    repeat (2) @(negedge clk);
    #1;
    resetn = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("midreset_no_rsp", rsp_seen, seen);

    // Recovery after reset
    slv_waits = 0;
    send(300, 1'b0, 5'd5, 32'h0, 4'b0000, 3'b000, 3, 32'hFFC0_1234, 1'b0, 1'b0, k1);
    bus.cmd_valid = 1'b0;
    drain();
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
